counter_updown_param: RTL
=========================

COUNTER_UPDOWN_PARAM -- requirements
Module: counter_updown_param

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits (2..32).
REQ-002 Parameter MODULUS, default 2**WIDTH, count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH).
REQ-003 Parameter SATURATE, default 0; 0 = wrap at range ends, 1 = hold at range ends.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  count enable; step only when high.
REQ-007 dir  input  1  1 = count up, 0 = count down.
REQ-008 load  input  1  parallel-load strobe (present only with COUNTER_LOAD_EN).
REQ-009 load_val  input  WIDTH  parallel-load value (present only with COUNTER_LOAD_EN).
REQ-010 count  output  WIDTH  registered counter value.
REQ-011 at_limit  output  1  combinational; high when count equals the end of range in the current dir (MODULUS-1 if dir=1, 0 if dir=0).
REQ-012 wrap  output  1  registered one-cycle pulse, high in the cycle after count wrapped or saturated-held at a limit while enabled.

Function
REQ-013 Priority per edge: reset > load > en > hold.
REQ-014 en=1, dir=1, count<MODULUS-1: count SHALL become count+1 next cycle.
REQ-015 en=1, dir=0, count>0: count SHALL become count-1 next cycle.
REQ-016 en=1, dir=1, count=MODULUS-1: SATURATE=0 -> count becomes 0; SATURATE=1 -> count holds; wrap=1 next cycle in both cases.
REQ-017 en=1, dir=0, count=0: SATURATE=0 -> count becomes MODULUS-1; SATURATE=1 -> count holds; wrap=1 next cycle in both cases.
REQ-018 en=0 and no load: count holds, wrap=0 next cycle.
REQ-019 load=1: count SHALL become load_val next cycle, clamped to MODULUS-1 if load_val >= MODULUS; wrap=0 next cycle; en and dir ignored that cycle.
REQ-020 Latency: one clock from en/load sample to updated count; at_limit has zero latency from count and dir.
REQ-021 dir change while en=1 takes effect on the same edge it is sampled; no idle cycle.
REQ-022 All arithmetic in WIDTH bits; no intermediate value SHALL exceed MODULUS-1 at count.
REQ-023 Non-power-of-two MODULUS SHALL never produce count >= MODULUS under any input sequence.

Reset
REQ-024 reset=1 at a rising edge: count=0, wrap=0 next cycle, regardless of load or en.
REQ-025 reset asserted mid-count SHALL discard the in-progress step; counting resumes from 0 on the first edge with reset=0.
REQ-026 No asynchronous reset path; count is undefined only before the first reset edge.

Configuration
REQ-027 Macro COUNTER_LOAD_EN defined: load and load_val ports exist with REQ-019 behaviour.
REQ-028 Macro COUNTER_LOAD_EN undefined: load and load_val ports absent; priority reduces to reset > en > hold; all other behaviour unchanged.

Structure
REQ-029 Shared package counter_pkg SHALL hold the mode constants (CNT_WRAP=0, CNT_SAT=1) and the dir encoding constants (CNT_UP=1, CNT_DOWN=0).
REQ-030 One sub-module counter_step (combinational: count, dir, MODULUS, SATURATE -> next value, limit flag) SHALL compute the step; the top holds registers and load/priority logic.

Verification (WIDTH=4, MODULUS=10 unless noted)
REQ-031 reset=1 with en=1, load=1, load_val=5 -> count=0, wrap=0 next cycle.
REQ-032 SATURATE=0, en=1, dir=1 from 0 for 11 cycles -> count 1..9, 0, 1; wrap=1 exactly in the cycle count reads 0.
REQ-033 SATURATE=0, en=1, dir=0 from 0 -> count=9, wrap=1; at_limit=1 while count=0 and dir=0.
REQ-034 SATURATE=1, dir=1, count=9, en=1 for 3 cycles -> count stays 9, wrap=1 each cycle; dir flipped to 0 -> count 8 next cycle, wrap=0.
REQ-035 COUNTER_LOAD_EN, load=1, load_val=13, en=1 -> count=9 next cycle; load_val=4 -> count=4.
REQ-036 WIDTH=8, MODULUS=256, SATURATE=0: up from 255 -> 0; down from 0 -> 255; reset mid-sequence at count=100 -> 0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter: saturate/wrap mode selectors and
// the encoding of the dir input.
package counter_pkg;

    localparam bit CNT_WRAP = 1'b0;
    localparam bit CNT_SAT  = 1'b1;

    localparam bit CNT_UP   = 1'b1;
    localparam bit CNT_DOWN = 1'b0;

endpackage : counter_pkg

// File: rtl/counter_step.sv
// Combinational step for the up/down counter: given the current value and
// direction, produce the next in-range value and the end-of-range flag.
module counter_step
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
    parameter bit              SATURATE = CNT_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic             dir,
    output logic [WIDTH-1:0] next_count,
    output logic             limit
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

    logic at_top;
    logic at_bottom;

    assign at_top    = (count == MAX_VAL);
    assign at_bottom = (count == '0);
    assign limit     = (dir == CNT_UP) ? at_top : at_bottom;

    // Range ends are detected by equality, so a non-power-of-two modulus never
    // lets the value step past MAX_VAL.
    always_comb begin
        next_count = count;
        if (dir == CNT_UP) begin
            if (!at_top) begin
                next_count = count + WIDTH'(1);
            end else if (SATURATE == CNT_WRAP) begin
                next_count = '0;
            end
        end else begin
            if (!at_bottom) begin
                next_count = count - WIDTH'(1);
            end else if (SATURATE == CNT_WRAP) begin
                next_count = MAX_VAL;
            end
        end
    end

endmodule : counter_step

// File: rtl/counter_updown_param.sv
// Parameterised up/down counter with wrap or saturate mode and a wrap pulse.
// Optional parallel load when COUNTER_LOAD_EN is defined.
module counter_updown_param
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
    parameter bit              SATURATE = CNT_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
`ifdef COUNTER_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`endif
    output logic [WIDTH-1:0] count,
    output logic             at_limit,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             wrap_reg;
    logic             wrap_next;
    logic [WIDTH-1:0] step_count;
    logic             step_limit;

    counter_step #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_step (
        .count      (count_reg),
        .dir        (dir),
        .next_count (step_count),
        .limit      (step_limit)
    );

    // Priority below reset: load, then enable, else hold.
    always_comb begin
        count_next = count_reg;
        wrap_next  = 1'b0;
`ifdef COUNTER_LOAD_EN
        if (load) begin
            count_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (en) begin
            count_next = step_count;
            wrap_next  = step_limit;
        end
`else
        if (en) begin
            count_next = step_count;
            wrap_next  = step_limit;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
            wrap_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign count    = count_reg;
    assign wrap     = wrap_reg;
    assign at_limit = step_limit;

endmodule : counter_updown_param
